// File: rtl/ulbf_capture_ram.sv
// AXI4-Stream capture buffer: start-armed, byte-enabled writes into a simple-dual-port RAM,
// packet counting against a target, linear/circular fill and a fixed-latency host read port.
module ulbf_capture_ram #(
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int unsigned DEPTH       = 8192,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned NITER_WIDTH = 12,
  parameter int unsigned RD_LATENCY  = 4
) (
  input  logic                   s_axis_clk,
  input  logic                   s_axis_aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   start,
  input  logic                   wrap_mode,
  input  logic [NITER_WIDTH-1:0] niter,
  output logic                   rxdone,
  output logic                   overflow,
  output logic                   wrapped,
  output logic [1:0]             state,
  output logic [ADDR_WIDTH:0]    wr_count,
  output logic [NITER_WIDTH-1:0] pkt_count,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [TDATA_WIDTH-1:0] rd_data,
  output logic                   rd_valid
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOP = 2'd1,
    ST_IN_PKT   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

  state_t                  st;
  logic [1:0]              rst_sync;
  logic                    rst_n;
  logic                    wrap_r;
  logic [NITER_WIDTH-1:0]  niter_r;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic                    accept;
  logic                    full;
  logic                    wr_en;
  logic [NITER_WIDTH-1:0]  pkt_next;
  logic                    hit_target;

  logic [TDATA_WIDTH-1:0]  mem [DEPTH];
  logic [TDATA_WIDTH-1:0]  rd_pipe [RD_LATENCY];
  logic [RD_LATENCY-1:0]   vld_pipe;

  // Reset asserts asynchronously, releases on the second clock edge.
  always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) rst_sync <= 2'b00;
    else                 rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_comb begin
    accept     = s_axis_tvalid & s_axis_tready & ~start;
    full       = (wr_count == DEPTH_CNT);
    wr_en      = accept & (wrap_r | ~full);
    pkt_next   = pkt_count + 1'b1;
    hit_target = (niter_r != '0) && (pkt_next == niter_r);
  end

  assign state = st;

  always_ff @(posedge s_axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= ST_IDLE;
      s_axis_tready <= 1'b0;
      wr_ptr        <= '0;
      wr_count      <= '0;
      pkt_count     <= '0;
      rxdone        <= 1'b0;
      overflow      <= 1'b0;
      wrapped       <= 1'b0;
      wrap_r        <= 1'b0;
      niter_r       <= '0;
    end else if (start) begin
      st            <= ST_WAIT_SOP;
      s_axis_tready <= 1'b1;
      wr_ptr        <= '0;
      wr_count      <= '0;
      pkt_count     <= '0;
      rxdone        <= 1'b0;
      overflow      <= 1'b0;
      wrapped       <= 1'b0;
      wrap_r        <= wrap_mode;
      niter_r       <= niter;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!full) wr_count <= wr_count + 1'b1;
        if (wrap_r && (wr_ptr == '1)) wrapped <= 1'b1;
      end
      if (accept && !wrap_r && full) overflow <= 1'b1;
      // Discarded beats still advance the packet state machine.
      if (accept) begin
        if (s_axis_tlast) begin
          pkt_count <= pkt_next;
          if (hit_target) begin
            st            <= ST_DONE;
            s_axis_tready <= 1'b0;
            rxdone        <= 1'b1;
          end else begin
            st <= ST_WAIT_SOP;
          end
        end else begin
          st <= ST_IN_PKT;
        end
      end
    end
  end

  always_ff @(posedge s_axis_clk) begin
    if (wr_en) begin
      for (int unsigned j = 0; j < TKEEP_WIDTH; j++) begin
        if (s_axis_tkeep[j]) mem[wr_ptr][j*8 +: 8] <= s_axis_tdata[j*8 +: 8];
      end
    end
  end

  // Data stages only advance behind a valid token, so rd_data holds between reads.
  always_ff @(posedge s_axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      if (rd_en) rd_pipe[0] <= mem[rd_addr];
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign rd_data  = rd_pipe[RD_LATENCY-1];
  assign rd_valid = vld_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_ulbf_capture_ram.sv
// Self-checking bench for ulbf_capture_ram: vector table, directed corner sequences and
// randomized traffic against a behavioural capture model.
module tb_ulbf_capture_ram;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned RDL   = 4;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        start = 1'b0;
  logic        wrap_mode = 1'b0;
  logic [11:0] niter = '0;
  logic        rxdone, overflow, wrapped;
  logic [1:0]  state;
  logic [4:0]  wr_count;
  logic [11:0] pkt_count;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        rd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the capture buffer
  logic [63:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_armed, m_done, m_mid, m_wrap, m_ovf, m_wrapped;
  int          m_ptr, m_cnt, m_pkt, m_niter;

  always #5 clk = ~clk;

  ulbf_capture_ram #(
    .TDATA_WIDTH (64),
    .DEPTH       (DEPTH),
    .NITER_WIDTH (12),
    .RD_LATENCY  (RDL)
  ) dut (
    .s_axis_clk     (clk),
    .s_axis_aresetn (aresetn),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tdata   (tdata),
    .s_axis_tkeep   (tkeep),
    .s_axis_tlast   (tlast),
    .start          (start),
    .wrap_mode      (wrap_mode),
    .niter          (niter),
    .rxdone         (rxdone),
    .overflow       (overflow),
    .wrapped        (wrapped),
    .state          (state),
    .wr_count       (wr_count),
    .pkt_count      (pkt_count),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_done = 0; m_mid = 0; m_wrap = 0; m_ovf = 0; m_wrapped = 0;
    m_ptr = 0; m_cnt = 0; m_pkt = 0; m_niter = 0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
  endtask

  task automatic check_outputs();
    int exp_state;
    exp_state = m_done ? 3 : (!m_armed ? 0 : (m_mid ? 2 : 1));
    check("tready",    64'(tready),    64'(m_armed && !m_done));
    check("state",     64'(state),     64'(exp_state));
    check("wr_count",  64'(wr_count),  64'(m_cnt));
    check("pkt_count", 64'(pkt_count), 64'(m_pkt));
    check("rxdone",    64'(rxdone),    64'(m_done));
    check("overflow",  64'(overflow),  64'(m_ovf));
    check("wrapped",   64'(wrapped),   64'(m_wrapped));
  endtask

  // One clock of stream stimulus; the model advances per the capture rules, then outputs are compared.
  task automatic step(input bit v, input logic [63:0] d, input logic [7:0] k, input bit l,
                      input bit st, input bit wm, input logic [11:0] ni);
    bit rdy;
    rdy = m_armed && !m_done;
    tvalid = v; tdata = d; tkeep = k; tlast = l; start = st; wrap_mode = wm; niter = ni;
    @(posedge clk); #1;
    if (st) begin
      m_armed = 1; m_done = 0; m_mid = 0; m_wrap = wm; m_niter = int'(ni);
      m_ptr = 0; m_cnt = 0; m_pkt = 0; m_ovf = 0; m_wrapped = 0;
    end else if (v && rdy) begin
      if (m_wrap || m_cnt < DEPTH) begin
        for (int j = 0; j < 8; j++) if (k[j]) m_mem[m_ptr][j*8 +: 8] = d[j*8 +: 8];
        m_known[m_ptr] = m_known[m_ptr] || (k == 8'hFF);
        if (m_wrap && m_ptr == DEPTH - 1) m_wrapped = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
      end else begin
        m_ovf = 1;
      end
      if (l) begin
        m_pkt = (m_pkt + 1) % 4096;
        m_mid = 0;
        if (m_niter != 0 && m_pkt == m_niter) m_done = 1;
      end else begin
        m_mid = 1;
      end
    end
    tvalid = 0; tlast = 0; start = 0;
    check_outputs();
  endtask

  // Single host read; cycle index of rd_valid counted from the rd_en cycle.
  task automatic read_check(input int addr, input string name);
    int lat;
    rd_en = 1; rd_addr = 4'(addr);
    @(posedge clk); #1;
    rd_en = 0; lat = 1;
    while (!rd_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_valid"}, 64'(rd_valid), 64'(1));
    if (rd_valid) begin
      check({name, "_latency"}, 64'(lat), 64'(RDL));
      if (m_known[addr]) check(name, rd_data, m_mem[addr]);
    end
  endtask

  typedef struct {
    bit          v;
    logic [63:0] d;
    bit          l;
    bit          st;
    logic [1:0]  e_state;
    bit          e_ready;
    int          e_wc;
    int          e_pkt;
    bit          e_done;
  } vec_t;

  vec_t        tbl [13];
  bit          r_v, r_l, r_st, r_wm;
  logic [7:0]  r_k;
  logic [11:0] r_ni;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    tbl[0]  = '{v:0, d:64'h0,    l:0, st:1, e_state:1, e_ready:1, e_wc:0,  e_pkt:0, e_done:0};
    tbl[1]  = '{v:1, d:64'hA000, l:0, st:0, e_state:2, e_ready:1, e_wc:1,  e_pkt:0, e_done:0};
    tbl[2]  = '{v:1, d:64'hA001, l:0, st:0, e_state:2, e_ready:1, e_wc:2,  e_pkt:0, e_done:0};
    tbl[3]  = '{v:1, d:64'hA002, l:0, st:0, e_state:2, e_ready:1, e_wc:3,  e_pkt:0, e_done:0};
    tbl[4]  = '{v:1, d:64'hA003, l:1, st:0, e_state:1, e_ready:1, e_wc:4,  e_pkt:1, e_done:0};
    tbl[5]  = '{v:1, d:64'hA004, l:0, st:0, e_state:2, e_ready:1, e_wc:5,  e_pkt:1, e_done:0};
    tbl[6]  = '{v:1, d:64'hA005, l:0, st:0, e_state:2, e_ready:1, e_wc:6,  e_pkt:1, e_done:0};
    tbl[7]  = '{v:1, d:64'hA006, l:0, st:0, e_state:2, e_ready:1, e_wc:7,  e_pkt:1, e_done:0};
    tbl[8]  = '{v:1, d:64'hA007, l:1, st:0, e_state:1, e_ready:1, e_wc:8,  e_pkt:2, e_done:0};
    tbl[9]  = '{v:1, d:64'hA008, l:0, st:0, e_state:2, e_ready:1, e_wc:9,  e_pkt:2, e_done:0};
    tbl[10] = '{v:1, d:64'hA009, l:0, st:0, e_state:2, e_ready:1, e_wc:10, e_pkt:2, e_done:0};
    tbl[11] = '{v:1, d:64'hA00A, l:0, st:0, e_state:2, e_ready:1, e_wc:11, e_pkt:2, e_done:0};
    tbl[12] = '{v:1, d:64'hA00B, l:1, st:0, e_state:3, e_ready:0, e_wc:12, e_pkt:3, e_done:1};

    model_reset();

    // Reset: outputs zero, rd_en ignored
    rd_en = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data",  rd_data, 64'h0);
    check_outputs();
    rd_en = 0;
    aresetn = 1;
    repeat (3) @(posedge clk);
    #1;
    step(1, 64'h1234, 8'hFF, 1, 0, 0, 12'd0);   // IDLE ignores traffic

    // Three 4-beat packets, niter=3, linear
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].d, 8'hFF, tbl[i].l, tbl[i].st, 0, 12'd3);
      check("tbl_state",  64'(state),     64'(tbl[i].e_state));
      check("tbl_tready", 64'(tready),    64'(tbl[i].e_ready));
      check("tbl_wc",     64'(wr_count),  64'(tbl[i].e_wc));
      check("tbl_pkt",    64'(pkt_count), 64'(tbl[i].e_pkt));
      check("tbl_rxdone", 64'(rxdone),    64'(tbl[i].e_done));
    end
    step(1, 64'hBAD, 8'hFF, 1, 0, 0, 12'd3);      // DONE holds, tready=0
    for (int a = 0; a < 12; a++) read_check(a, "t1_rd");

    // Byte-enable merge
    step(0, 64'h0, 8'h00, 0, 1, 0, 12'd0);
    step(1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, 0, 0, 12'd0);
    step(0, 64'h0, 8'h00, 0, 1, 0, 12'd0);
    step(1, 64'h0123_4567_89AB_CDEF, 8'h0F, 1, 0, 0, 12'd0);
    read_check(0, "tkeep_rd");
    check("tkeep_merge", rd_data, 64'hFFFF_FFFF_89AB_CDEF);

    // Linear overflow with 20 beats
    step(0, 64'h0, 8'h00, 0, 1, 0, 12'd0);
    for (int b = 0; b < 20; b++) step(1, {$urandom, $urandom}, 8'hFF, (b % 5) == 4, 0, 0, 12'd0);
    check("lin_overflow", 64'(overflow), 64'(1));
    check("lin_wr_count", 64'(wr_count), 64'(16));
    check("lin_tready",   64'(tready),   64'(1));
    for (int a = 0; a < 16; a++) read_check(a, "lin_rd");

    // Circular wrap with 20 beats
    step(0, 64'h0, 8'h00, 0, 1, 1, 12'd0);
    for (int b = 0; b < 20; b++) step(1, 64'hC0DE_0000 + 64'(b), 8'hFF, (b % 5) == 4, 0, 0, 12'd0);
    check("circ_wrapped",  64'(wrapped),  64'(1));
    check("circ_overflow", 64'(overflow), 64'(0));
    check("circ_rd_addr3_src", m_mem[3], 64'hC0DE_0013);
    for (int a = 0; a < 16; a++) read_check(a, "circ_rd");

    // Back-to-back reads of 0,1,2: valid in cycles 4,5,6 then data holds
    for (int k = 1; k <= 9; k++) begin
      rd_en = (k <= 3);
      rd_addr = 4'(k - 1);
      @(posedge clk); #1;
      check("b2b_valid", 64'(rd_valid), 64'((k >= 4) && (k <= 6)));
      if (k >= 4 && k <= 6) check("b2b_data", rd_data, m_mem[k-4]);
      if (k >= 7) check("rd_hold", rd_data, m_mem[2]);
    end
    rd_en = 0;

    // Reset mid-packet, then start colliding with an accept
    step(0, 64'h0, 8'h00, 0, 1, 0, 12'd0);
    step(1, 64'h1111, 8'hFF, 0, 0, 0, 12'd0);
    step(1, 64'h2222, 8'hFF, 0, 0, 0, 12'd0);
    #2 aresetn = 0;
    #1;
    model_reset();
    check("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
    check("mid_rst_rd_data",  rd_data, 64'h0);
    check_outputs();
    repeat (2) @(posedge clk);
    #1 aresetn = 1;
    repeat (3) @(posedge clk);
    #1;
    step(1, 64'h3333, 8'hFF, 0, 0, 0, 12'd0);
    step(1, 64'hDEAD, 8'hFF, 0, 1, 0, 12'd0);    // start wins; beat dropped
    step(1, 64'h5555, 8'hFF, 1, 0, 0, 12'd0);
    read_check(0, "post_rst_rd");
    check("post_rst_addr0", rd_data, 64'h5555);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r_st = (i == 0) || ($urandom_range(0, 39) == 0);
      r_v  = ($urandom_range(0, 3) != 0);
      r_l  = ($urandom_range(0, 3) == 0);
      r_wm = ($urandom_range(0, 1) == 1);
      r_k  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      r_ni = 12'($urandom_range(0, 4));
      step(r_v, {$urandom, $urandom}, r_k, r_l, r_st, r_wm, r_ni);
      if ($urandom_range(0, 15) == 0) read_check(int'($urandom_range(0, 15)), "rand_rd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
